// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

   localparam int unsigned DEST_W      = 8;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned FWD_REGFILE = 0;

   // One tracked post-decode pipeline slot.
   typedef struct packed {
      logic              valid;
      logic [DEST_W-1:0] dest;
      logic              wen;
      logic              load;
      logic              multi;
   } slot_t;

endpackage

// File: rtl/hazard_slot_match.sv
// Per-slot source match against the instruction in D, plus load-dependency flag.
module hazard_slot_match
   import hazard_pkg::*;
(
   input  slot_t             slot,
   input  logic [DEST_W-1:0] reg1Address,
   input  logic [DEST_W-1:0] reg2Address,
   input  logic              use1,
   input  logic              use2,
   output logic              match1,
   output logic              match2,
   output logic              loadHit
);

   logic producer;
   logic unusedMulti;

   assign producer    = slot.valid & slot.wen;
   assign match1      = producer & use1 & (slot.dest == reg1Address) & (reg1Address != '0);
   assign match2      = producer & use2 & (slot.dest == reg2Address) & (reg2Address != '0);
   assign loadHit     = slot.load & (match1 | match2);
   assign unusedMulti = slot.multi;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight destinations, raises
// stall/flush/hold/bubble controls and registers forward selects for E.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned ADDRESSWIDTH = 4,
   parameter int unsigned STAGES       = 3,
   parameter int unsigned LOADSTAGE    = 2,
   parameter int unsigned MCLAT        = 4,
   parameter int unsigned FSW          = $clog2(STAGES)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    validD,
   input  logic [ADDRESSWIDTH-1:0] reg1AddressD,
   input  logic [ADDRESSWIDTH-1:0] reg2AddressD,
   input  logic                    use1D,
   input  logic                    use2D,
   input  logic [ADDRESSWIDTH-1:0] regDestinationAddressD,
   input  logic                    writeEnableD,
   input  logic                    isLoadD,
   input  logic                    isMultiD,
   input  logic                    takeBranchE,
   output logic                    stallF,
   output logic                    stallD,
   output logic                    flushD,
   output logic                    flushE,
   output logic                    holdE,
   output logic                    bubbleM,
   output logic [FSW-1:0]          data1ForwardSelectorE,
   output logic [FSW-1:0]          data2ForwardSelectorE
);

   if (STAGES < 2 || STAGES > 8 || LOADSTAGE < 1 || LOADSTAGE >= STAGES ||
       MCLAT < 1 || MCLAT > 15 || ADDRESSWIDTH < 1 || ADDRESSWIDTH > DEST_W) begin : gBadParams
      $error("pipeline_hazard_ctrl: illegal parameter combination");
   end

   slot_t             slots [1:STAGES];
   slot_t             slotD;
   logic [DEST_W-1:0] reg1Wide;
   logic [DEST_W-1:0] reg2Wide;
   logic [STAGES:1]   match1;
   logic [STAGES:1]   match2;
   logic [STAGES:1]   loadHit;
   logic [CNT_W-1:0]  cnt;
   logic [FSW-1:0]    fwd1;
   logic [FSW-1:0]    fwd2;
   logic [FSW-1:0]    fwd1Next;
   logic [FSW-1:0]    fwd2Next;
   logic              luAny;
   logic              luStall;
   logic              hold;
   logic              stallInt;
   logic              advance;
   logic              unusedBits;

   assign reg1Wide = DEST_W'(reg1AddressD);
   assign reg2Wide = DEST_W'(reg2AddressD);

   always_comb begin
      slotD       = '0;
      slotD.valid = validD;
      slotD.dest  = DEST_W'(regDestinationAddressD);
      slotD.wen   = writeEnableD;
      slotD.load  = isLoadD;
      slotD.multi = isMultiD;
   end

   for (genvar s = 1; s <= STAGES; s++) begin : gSlot
      hazard_slot_match uMatch (
         .slot        (slots[s]),
         .reg1Address (reg1Wide),
         .reg2Address (reg2Wide),
         .use1        (use1D),
         .use2        (use2D),
         .match1      (match1[s]),
         .match2      (match2[s]),
         .loadHit     (loadHit[s])
      );
   end

   // Only producers younger than the load-result slot force a stall.
   if (LOADSTAGE > 1) begin : gLoadUse
      assign luAny = |loadHit[LOADSTAGE-1:1];
   end else begin : gNoLoadUse
      assign luAny = 1'b0;
   end

   // The WB slot is excluded: register-file write-through covers it.
   always_comb begin
      fwd1Next = FSW'(FWD_REGFILE);
      fwd2Next = FSW'(FWD_REGFILE);
      for (int s = int'(STAGES) - 1; s >= 1; s--) begin
         if (match1[s]) fwd1Next = FSW'(s);
         if (match2[s]) fwd2Next = FSW'(s);
      end
   end

   assign luStall  = validD & luAny;
   assign hold     = (cnt != '0);
   assign stallInt = (luStall | hold) & ~takeBranchE;
   assign advance  = validD & ~stallInt & ~takeBranchE & ~hold;

   assign stallF  = stallInt & ~reset;
   assign stallD  = stallInt & ~reset;
   assign flushD  = takeBranchE | reset;
   assign flushE  = takeBranchE | (luStall & ~hold) | reset;
   assign holdE   = hold & ~reset;
   assign bubbleM = hold & ~reset;

   assign data1ForwardSelectorE = fwd1;
   assign data2ForwardSelectorE = fwd2;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 1; s <= int'(STAGES); s++) slots[s] <= '0;
         cnt  <= '0;
         fwd1 <= FSW'(FWD_REGFILE);
         fwd2 <= FSW'(FWD_REGFILE);
      end else begin
         // While E holds, slot1 keeps the multi op and a bubble enters slot2.
         if (hold) begin
            slots[2] <= '0;
            for (int s = 3; s <= int'(STAGES); s++) slots[s] <= slots[s-1];
         end else begin
            slots[1] <= advance ? slotD : '0;
            for (int s = 2; s <= int'(STAGES); s++) slots[s] <= slots[s-1];
         end

         if (advance && isMultiD) cnt <= CNT_W'(MCLAT - 1);
         else if (hold)           cnt <= cnt - CNT_W'(1);

         if (advance) begin
            fwd1 <= fwd1Next;
            fwd2 <= fwd2Next;
         end else if (!hold) begin
            fwd1 <= FSW'(FWD_REGFILE);
            fwd2 <= FSW'(FWD_REGFILE);
         end
      end
   end

   branchNotDuringMulti : assert property (@(posedge clock) disable iff (reset)
      !(takeBranchE && hold && slots[1].multi));

   assign unusedBits = ^{match1[STAGES], match2[STAGES], loadHit};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default (STAGES=3) and a deep (STAGES=5) instance.
module tb_pipeline_hazard_ctrl;

   logic       clock;
   logic       reset;
   logic       validD;
   logic [3:0] reg1AddressD;
   logic [3:0] reg2AddressD;
   logic       use1D;
   logic       use2D;
   logic [3:0] regDestinationAddressD;
   logic       writeEnableD;
   logic       isLoadD;
   logic       isMultiD;
   logic       takeBranchE;

   logic       stallF3, stallD3, flushD3, flushE3, holdE3, bubbleM3;
   logic [1:0] fwd1Sel3, fwd2Sel3;
   logic       stallF5, stallD5, flushD5, flushE5, holdE5, bubbleM5;
   logic [2:0] fwd1Sel5, fwd2Sel5;
   logic [5:0] ctl3;
   logic [5:0] ctl5;

   int nChecks;
   int nFails;

   assign ctl3 = {stallF3, stallD3, flushD3, flushE3, holdE3, bubbleM3};
   assign ctl5 = {stallF5, stallD5, flushD5, flushE5, holdE5, bubbleM5};

   pipeline_hazard_ctrl dut3 (
      .clock(clock), .reset(reset), .validD(validD),
      .reg1AddressD(reg1AddressD), .reg2AddressD(reg2AddressD),
      .use1D(use1D), .use2D(use2D),
      .regDestinationAddressD(regDestinationAddressD), .writeEnableD(writeEnableD),
      .isLoadD(isLoadD), .isMultiD(isMultiD), .takeBranchE(takeBranchE),
      .stallF(stallF3), .stallD(stallD3), .flushD(flushD3), .flushE(flushE3),
      .holdE(holdE3), .bubbleM(bubbleM3),
      .data1ForwardSelectorE(fwd1Sel3), .data2ForwardSelectorE(fwd2Sel3)
   );

   pipeline_hazard_ctrl #(.STAGES(5)) dut5 (
      .clock(clock), .reset(reset), .validD(validD),
      .reg1AddressD(reg1AddressD), .reg2AddressD(reg2AddressD),
      .use1D(use1D), .use2D(use2D),
      .regDestinationAddressD(regDestinationAddressD), .writeEnableD(writeEnableD),
      .isLoadD(isLoadD), .isMultiD(isMultiD), .takeBranchE(takeBranchE),
      .stallF(stallF5), .stallD(stallD5), .flushD(flushD5), .flushE(flushE5),
      .holdE(holdE5), .bubbleM(bubbleM5),
      .data1ForwardSelectorE(fwd1Sel5), .data2ForwardSelectorE(fwd2Sel5)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic setD(input logic v, input logic [3:0] a1, input logic [3:0] a2,
                       input logic u1, input logic u2, input logic [3:0] dst,
                       input logic we, input logic ld, input logic mul);
      validD = v; reg1AddressD = a1; reg2AddressD = a2; use1D = u1; use2D = u2;
      regDestinationAddressD = dst; writeEnableD = we; isLoadD = ld; isMultiD = mul;
   endtask

   task automatic setNop();
      setD(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      setNop();
      repeat (6) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; takeBranchE = 1'b0; setNop();
      tick();
      #1;
      nChecks++;
      if (ctl3 !== 6'b001100) begin nFails++; $display("FAIL reset_ctl3 got=%b want=%b", ctl3, 6'b001100); end
      nChecks++;
      if (ctl5 !== 6'b001100) begin nFails++; $display("FAIL reset_ctl5 got=%b want=%b", ctl5, 6'b001100); end
      tick();
      reset = 1'b0;
      #1;
      nChecks++;
      if (ctl3 !== 6'b000000) begin nFails++; $display("FAIL post_reset_ctl got=%b want=%b", ctl3, 6'b000000); end
      nChecks++;
      if ({fwd1Sel3, fwd2Sel3} !== 4'b0000) begin nFails++; $display("FAIL post_reset_sel3 got=%b want=%b", {fwd1Sel3, fwd2Sel3}, 4'b0000); end
      nChecks++;
      if ({fwd1Sel5, fwd2Sel5} !== 6'b000000) begin nFails++; $display("FAIL post_reset_sel5 got=%b want=%b", {fwd1Sel5, fwd2Sel5}, 6'b000000); end
   endtask

   task automatic test_forward();
      drain();
      setD(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);   // ADD r3
      #1;
      nChecks++;
      if (ctl3 !== 6'b000000) begin nFails++; $display("FAIL fwd_add_ctl got=%b want=%b", ctl3, 6'b000000); end
      tick();
      setD(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);   // SUB r4,r3,r5
      #1;
      nChecks++;
      if (ctl3 !== 6'b000000) begin nFails++; $display("FAIL fwd_sub_ctl got=%b want=%b", ctl3, 6'b000000); end
      tick();
      setD(1'b1, 4'd10, 4'd11, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0); // independent
      #1;
      nChecks++;
      if (fwd1Sel3 !== 2'd1) begin nFails++; $display("FAIL fwd_sub_sel1 got=%0d want=%0d", fwd1Sel3, 1); end
      nChecks++;
      if (fwd2Sel3 !== 2'd0) begin nFails++; $display("FAIL fwd_sub_sel2 got=%0d want=%0d", fwd2Sel3, 0); end
      tick();
      setNop();
      #1;
      nChecks++;
      if (fwd1Sel3 !== 2'd0) begin nFails++; $display("FAIL fwd_indep_sel1 got=%0d want=%0d", fwd1Sel3, 0); end

      // r0 is never forwarded, and an unused source never matches.
      drain();
      setD(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
      tick();
      setD(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
      tick();
      setNop();
      #1;
      nChecks++;
      if ({fwd1Sel3, fwd2Sel3} !== 4'b0000) begin nFails++; $display("FAIL fwd_r0 got=%b want=%b", {fwd1Sel3, fwd2Sel3}, 4'b0000); end
      drain();
      setD(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
      tick();
      setD(1'b1, 4'd3, 4'd3, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
      tick();
      setNop();
      #1;
      nChecks++;
      if ({fwd1Sel3, fwd2Sel3} !== 4'b0001) begin nFails++; $display("FAIL fwd_use_gate got=%b want=%b", {fwd1Sel3, fwd2Sel3}, 4'b0001); end
   endtask

   task automatic test_load_use();
      drain();
      setD(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0);   // LW r2
      #1;
      nChecks++;
      if (ctl3 !== 6'b000000) begin nFails++; $display("FAIL lu_lw_ctl got=%b want=%b", ctl3, 6'b000000); end
      tick();
      setD(1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);   // ADD r6,r2,r2
      #1;
      nChecks++;
      if (ctl3 !== 6'b110100) begin nFails++; $display("FAIL lu_stall_ctl got=%b want=%b", ctl3, 6'b110100); end
      tick();
      #1;
      nChecks++;
      if (ctl3 !== 6'b000000) begin nFails++; $display("FAIL lu_one_cycle got=%b want=%b", ctl3, 6'b000000); end
      nChecks++;
      if (fwd1Sel3 !== 2'd0) begin nFails++; $display("FAIL lu_bubble_sel got=%0d want=%0d", fwd1Sel3, 0); end
      tick();
      setNop();
      #1;
      // LW has reached WB by the time ADD is in E: select 2 (output of slot 3).
      nChecks++;
      if ({fwd1Sel3, fwd2Sel3} !== 4'b1010) begin nFails++; $display("FAIL lu_sel got=%b want=%b", {fwd1Sel3, fwd2Sel3}, 4'b1010); end
   endtask

   task automatic test_multi();
      drain();
      setD(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1);   // MUL r7
      #1;
      nChecks++;
      if (ctl3 !== 6'b000000) begin nFails++; $display("FAIL mul_issue_ctl got=%b want=%b", ctl3, 6'b000000); end
      tick();
      setD(1'b1, 4'd7, 4'd1, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);   // ADD r8,r7,r1
      for (int c = 0; c < 3; c++) begin
         #1;
         nChecks++;
         if (ctl3 !== 6'b110011) begin nFails++; $display("FAIL mul_hold_ctl cycle=%0d got=%b want=%b", c, ctl3, 6'b110011); end
         tick();
      end
      #1;
      nChecks++;
      if (ctl3 !== 6'b000000) begin nFails++; $display("FAIL mul_release_ctl got=%b want=%b", ctl3, 6'b000000); end
      tick();
      setNop();
      #1;
      nChecks++;
      if ({fwd1Sel3, fwd2Sel3} !== 4'b0100) begin nFails++; $display("FAIL mul_sel got=%b want=%b", {fwd1Sel3, fwd2Sel3}, 4'b0100); end
   endtask

   task automatic test_reset_mid_multi();
      drain();
      setD(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1);
      tick();
      setNop();
      #1;
      nChecks++;
      if (ctl3 !== 6'b110011) begin nFails++; $display("FAIL rmm_hold got=%b want=%b", ctl3, 6'b110011); end
      reset = 1'b1;
      #1;
      nChecks++;
      if (ctl3 !== 6'b001100) begin nFails++; $display("FAIL rmm_in_reset got=%b want=%b", ctl3, 6'b001100); end
      tick();
      reset = 1'b0;
      #1;
      nChecks++;
      if (ctl3 !== 6'b000000) begin nFails++; $display("FAIL rmm_cleared got=%b want=%b", ctl3, 6'b000000); end
   endtask

   task automatic test_branch();
      drain();
      setD(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0);   // LW r2
      tick();
      setD(1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);   // ADD r6,r2,r2
      takeBranchE = 1'b1;
      #1;
      nChecks++;
      if (ctl3 !== 6'b001100) begin nFails++; $display("FAIL br_ctl got=%b want=%b", ctl3, 6'b001100); end
      tick();
      takeBranchE = 1'b0;
      setD(1'b1, 4'd6, 4'd2, 1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0);  // reads r6 and r2
      #1;
      nChecks++;
      if (ctl3 !== 6'b000000) begin nFails++; $display("FAIL br_next_ctl got=%b want=%b", ctl3, 6'b000000); end
      tick();
      setNop();
      #1;
      // Flushed ADD never entered slot1; LW still tracked in slot2.
      nChecks++;
      if ({fwd1Sel3, fwd2Sel3} !== 4'b0010) begin nFails++; $display("FAIL br_sel got=%b want=%b", {fwd1Sel3, fwd2Sel3}, 4'b0010); end
   endtask

   task automatic test_back_to_back();
      int gaps [4];
      int exp3 [4];
      int exp5 [4];
      gaps = '{0, 1, 3, 4};
      exp3 = '{1, 2, 0, 0};
      exp5 = '{1, 2, 4, 0};
      for (int i = 0; i < 4; i++) begin
         drain();
         setD(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
         tick();
         for (int g = 0; g < gaps[i]; g++) begin
            setD(1'b1, 4'd10, 4'd11, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
            tick();
         end
         setD(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
         tick();
         setNop();
         #1;
         nChecks++;
         if (fwd1Sel5 !== 3'(exp5[i])) begin nFails++; $display("FAIL b2b_sel5 gap=%0d got=%0d want=%0d", gaps[i], fwd1Sel5, exp5[i]); end
         nChecks++;
         if (fwd1Sel3 !== 2'(exp3[i])) begin nFails++; $display("FAIL b2b_sel3 gap=%0d got=%0d want=%0d", gaps[i], fwd1Sel3, exp3[i]); end
      end
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      test_reset();
      test_forward();
      test_load_use();
      test_multi();
      test_reset_mid_multi();
      test_branch();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
